// File: rtl/axi_master_pkg.sv
// axi_master_pkg: shared types and constants for the AXI burst master.
// Holds the FSM state encoding, AXI burst/response codes and resp_max().
package axi_master_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WADDR,
      WDATA,
      WRESP,
      RADDR,
      RDATA,
      DONE
   } state_t;

   localparam logic [1:0] BURST_INCR  = 2'b01;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Numerically larger AXI RESP codes are the more severe outcome.
   function automatic logic [1:0] resp_max(
      input logic [1:0] a,
      input logic [1:0] b
   );
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/AXI_INF.sv
// AXI_INF: AXI4 bus bundle with master (M) and slave (S) views.
// Only the signals the burst master and its slave models need.
interface AXI_INF #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ID_W   = 4
);
   localparam int unsigned STRB_W = DATA_W / 8;

   logic [ID_W-1:0]   WR_ADDR_ID;
   logic [ADDR_W-1:0] WR_ADDR;
   logic [7:0]        WR_ADDR_LEN;
   logic [2:0]        WR_ADDR_SIZE;
   logic [1:0]        WR_ADDR_BURST;
   logic              WR_ADDR_VALID;
   logic              WR_ADDR_READY;

   logic [DATA_W-1:0] WR_DATA;
   logic [STRB_W-1:0] WR_STRB;
   logic              WR_DATA_LAST;
   logic              WR_DATA_VALID;
   logic              WR_DATA_READY;

   logic [ID_W-1:0]   WR_BACK_ID;
   logic [1:0]        WR_BACK_RESP;
   logic              WR_BACK_VALID;
   logic              WR_BACK_READY;

   logic [ID_W-1:0]   RD_ADDR_ID;
   logic [ADDR_W-1:0] RD_ADDR;
   logic [7:0]        RD_ADDR_LEN;
   logic [2:0]        RD_ADDR_SIZE;
   logic [1:0]        RD_ADDR_BURST;
   logic              RD_ADDR_VALID;
   logic              RD_ADDR_READY;

   logic [ID_W-1:0]   RD_BACK_ID;
   logic [DATA_W-1:0] RD_DATA;
   logic [1:0]        RD_DATA_RESP;
   logic              RD_DATA_LAST;
   logic              RD_DATA_VALID;
   logic              RD_DATA_READY;

   modport M (
      output WR_ADDR_ID, WR_ADDR, WR_ADDR_LEN, WR_ADDR_SIZE,
      output WR_ADDR_BURST, WR_ADDR_VALID,
      input  WR_ADDR_READY,
      output WR_DATA, WR_STRB, WR_DATA_LAST, WR_DATA_VALID,
      input  WR_DATA_READY,
      input  WR_BACK_ID, WR_BACK_RESP, WR_BACK_VALID,
      output WR_BACK_READY,
      output RD_ADDR_ID, RD_ADDR, RD_ADDR_LEN, RD_ADDR_SIZE,
      output RD_ADDR_BURST, RD_ADDR_VALID,
      input  RD_ADDR_READY,
      input  RD_BACK_ID, RD_DATA, RD_DATA_RESP, RD_DATA_LAST,
      input  RD_DATA_VALID,
      output RD_DATA_READY
   );

   modport S (
      input  WR_ADDR_ID, WR_ADDR, WR_ADDR_LEN, WR_ADDR_SIZE,
      input  WR_ADDR_BURST, WR_ADDR_VALID,
      output WR_ADDR_READY,
      input  WR_DATA, WR_STRB, WR_DATA_LAST, WR_DATA_VALID,
      output WR_DATA_READY,
      output WR_BACK_ID, WR_BACK_RESP, WR_BACK_VALID,
      input  WR_BACK_READY,
      input  RD_ADDR_ID, RD_ADDR, RD_ADDR_LEN, RD_ADDR_SIZE,
      input  RD_ADDR_BURST, RD_ADDR_VALID,
      output RD_ADDR_READY,
      output RD_BACK_ID, RD_DATA, RD_DATA_RESP, RD_DATA_LAST,
      output RD_DATA_VALID,
      input  RD_DATA_READY
   );

endinterface

// File: rtl/axi_master_watchdog.sv
// axi_master_watchdog: stall counter for the burst master.
// expire pulses after TIMEOUT active cycles with no kick.
module axi_master_watchdog #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic kick,
   output logic expire
);
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || !active || kick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expire = active && !kick && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/axi_master_burst.sv
// axi_master_burst: command-driven AXI4 INCR burst master.
// Define AXI_MASTER_TIMEOUT_EN to add the stall watchdog.
module axi_master_burst
   import axi_master_pkg::*;
#(
   parameter logic [3:0]  ID      = 4'd0,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [7:0]        cmd_len,
   input  logic [DATA_W-1:0] wdat,
   input  logic              wdat_valid,
   output logic              wdat_ready,
   output logic [DATA_W-1:0] rdat,
   output logic              rdat_last,
   output logic              rdat_valid,
   input  logic              rdat_ready,
   output logic              done,
   output logic [1:0]        done_resp,
   output logic              done_err,
   AXI_INF.M                 AXI_M
);
   localparam logic [2:0] SIZE = 3'($clog2(DATA_W / 8));

   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        len_q;
   logic [7:0]        beat_cnt;
   logic [1:0]        resp_acc;
   logic              err_q;
   logic              wa_valid_q;
   logic              ra_valid_q;
   logic              wb_ready_q;

   logic       last_beat;
   logic       in_wdata;
   logic       in_rdata;
   logic       wa_hs;
   logic       ra_hs;
   logic       wd_hs;
   logic       wb_hs;
   logic       rd_hs;
   logic       rd_beat_err;
   logic [1:0] rd_resp_nxt;
   logic       timeout;

   assign last_beat = (beat_cnt == len_q);
   assign in_wdata  = (state == WDATA);
   assign in_rdata  = (state == RDATA);

   assign AXI_M.WR_ADDR_ID    = ID;
   assign AXI_M.WR_ADDR       = addr_q;
   assign AXI_M.WR_ADDR_LEN   = len_q;
   assign AXI_M.WR_ADDR_SIZE  = SIZE;
   assign AXI_M.WR_ADDR_BURST = BURST_INCR;
   assign AXI_M.WR_ADDR_VALID = wa_valid_q;

   assign AXI_M.WR_DATA       = wdat;
   assign AXI_M.WR_STRB       = '1;
   assign AXI_M.WR_DATA_LAST  = in_wdata && last_beat;
   assign AXI_M.WR_DATA_VALID = in_wdata && wdat_valid;
   assign wdat_ready          = in_wdata && AXI_M.WR_DATA_READY;
   assign AXI_M.WR_BACK_READY = wb_ready_q;

   assign AXI_M.RD_ADDR_ID    = ID;
   assign AXI_M.RD_ADDR       = addr_q;
   assign AXI_M.RD_ADDR_LEN   = len_q;
   assign AXI_M.RD_ADDR_SIZE  = SIZE;
   assign AXI_M.RD_ADDR_BURST = BURST_INCR;
   assign AXI_M.RD_ADDR_VALID = ra_valid_q;

   assign AXI_M.RD_DATA_READY = in_rdata && rdat_ready;
   assign rdat                = AXI_M.RD_DATA;
   assign rdat_valid          = in_rdata && AXI_M.RD_DATA_VALID;
   assign rdat_last           = in_rdata && last_beat;

   assign wa_hs = wa_valid_q && AXI_M.WR_ADDR_READY;
   assign ra_hs = ra_valid_q && AXI_M.RD_ADDR_READY;
   assign wd_hs = in_wdata && wdat_valid && AXI_M.WR_DATA_READY;
   assign wb_hs = wb_ready_q && AXI_M.WR_BACK_VALID;
   assign rd_hs = in_rdata && AXI_M.RD_DATA_VALID && rdat_ready;

   assign rd_beat_err = (AXI_M.RD_BACK_ID != ID) ||
                        (AXI_M.RD_DATA_LAST != last_beat);
   assign rd_resp_nxt = resp_max(resp_acc, AXI_M.RD_DATA_RESP);

`ifdef AXI_MASTER_TIMEOUT_EN
   logic wd_active;
   logic wd_kick;

   assign wd_active = (state != IDLE) && (state != DONE);
   assign wd_kick   = wa_hs || ra_hs || wd_hs || wb_hs || rd_hs;

   axi_master_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .active (wd_active),
      .kick   (wd_kick),
      .expire (timeout)
   );
`else
   logic unused_timeout;

   assign timeout        = 1'b0;
   assign unused_timeout = ^TIMEOUT;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cmd_ready  <= 1'b0;
         addr_q     <= '0;
         len_q      <= '0;
         beat_cnt   <= '0;
         resp_acc   <= RESP_OKAY;
         err_q      <= 1'b0;
         wa_valid_q <= 1'b0;
         ra_valid_q <= 1'b0;
         wb_ready_q <= 1'b0;
         done       <= 1'b0;
         done_resp  <= RESP_OKAY;
         done_err   <= 1'b0;
      end else if (timeout) begin
         state      <= DONE;
         wa_valid_q <= 1'b0;
         ra_valid_q <= 1'b0;
         wb_ready_q <= 1'b0;
         done       <= 1'b1;
         done_resp  <= RESP_SLVERR;
         done_err   <= 1'b1;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready  <= 1'b0;
                  addr_q     <= cmd_addr;
                  len_q      <= cmd_len;
                  beat_cnt   <= '0;
                  resp_acc   <= RESP_OKAY;
                  err_q      <= 1'b0;
                  wa_valid_q <= cmd_write;
                  ra_valid_q <= !cmd_write;
                  state      <= cmd_write ? WADDR : RADDR;
               end
            end
            WADDR: begin
               if (wa_hs) begin
                  wa_valid_q <= 1'b0;
                  state      <= WDATA;
               end
            end
            WDATA: begin
               if (wd_hs) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (last_beat) begin
                     wb_ready_q <= 1'b1;
                     state      <= WRESP;
                  end
               end
            end
            WRESP: begin
               if (wb_hs) begin
                  wb_ready_q <= 1'b0;
                  done       <= 1'b1;
                  done_resp  <= AXI_M.WR_BACK_RESP;
                  done_err   <= err_q || (AXI_M.WR_BACK_ID != ID);
                  state      <= DONE;
               end
            end
            RADDR: begin
               if (ra_hs) begin
                  ra_valid_q <= 1'b0;
                  state      <= RDATA;
               end
            end
            RDATA: begin
               if (rd_hs) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  resp_acc <= rd_resp_nxt;
                  err_q    <= err_q || rd_beat_err;
                  // The counted length, not the slave's LAST, ends the burst.
                  if (last_beat) begin
                     done      <= 1'b1;
                     done_resp <= rd_resp_nxt;
                     done_err  <= err_q || rd_beat_err;
                     state     <= DONE;
                  end
               end
            end
            DONE: begin
               cmd_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_master_burst.sv
// tb_axi_master_burst: directed scoreboard bench for axi_master_burst.
// A behavioural AXI slave answers; a negedge monitor checks queued expectations.
module tb_axi_master_burst;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_addr = '0;
   logic [7:0]  cmd_len = '0;
   logic [31:0] wdat = '0;
   logic        wdat_valid = 1'b0;
   logic        wdat_ready;
   logic [31:0] rdat;
   logic        rdat_last;
   logic        rdat_valid;
   logic        rdat_ready = 1'b1;
   logic        done;
   logic [1:0]  done_resp;
   logic        done_err;

   AXI_INF #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) axi ();

   axi_master_burst #(
      .ID      (4'd0),
      .ADDR_W  (32),
      .DATA_W  (32),
      .TIMEOUT (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_write  (cmd_write),
      .cmd_addr   (cmd_addr),
      .cmd_len    (cmd_len),
      .wdat       (wdat),
      .wdat_valid (wdat_valid),
      .wdat_ready (wdat_ready),
      .rdat       (rdat),
      .rdat_last  (rdat_last),
      .rdat_valid (rdat_valid),
      .rdat_ready (rdat_ready),
      .done       (done),
      .done_resp  (done_resp),
      .done_err   (done_err),
      .AXI_M      (axi.M)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_done   = 0;

   // Scoreboard queues: {addr,len,burst,size,id}, {strb,data,last},
   // {data,last}, {resp,err}.
   logic [48:0] exp_aw[$];
   logic [48:0] exp_ar[$];
   logic [36:0] exp_w[$];
   logic [32:0] exp_r[$];
   logic [2:0]  exp_done[$];

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got event expected none", name);
   endtask

   // Behavioural slave.
   logic        ready_aw = 1'b1;
   logic        ready_ar = 1'b1;
   logic        ready_w  = 1'b1;
   logic [1:0]  bresp_cfg = 2'b00;
   logic [3:0]  bid_cfg = 4'd0;
   logic [3:0]  rid_cfg = 4'd0;
   logic [7:0]  rlast_at = 8'd0;
   logic [31:0] rdata_tab [256];
   logic [1:0]  rresp_tab [256];
   logic [7:0]  r_beat;
   logic [7:0]  r_len;

   assign axi.WR_ADDR_READY = ready_aw;
   assign axi.RD_ADDR_READY = ready_ar;
   assign axi.WR_DATA_READY = ready_w;
   assign axi.RD_DATA       = rdata_tab[r_beat];
   assign axi.RD_DATA_RESP  = rresp_tab[r_beat];
   assign axi.RD_DATA_LAST  = (r_beat == rlast_at);
   assign axi.RD_BACK_ID    = rid_cfg;

   always @(posedge clk) begin
      if (rst) begin
         axi.WR_BACK_VALID <= 1'b0;
         axi.WR_BACK_RESP  <= 2'b00;
         axi.WR_BACK_ID    <= 4'd0;
         axi.RD_DATA_VALID <= 1'b0;
         r_beat            <= 8'd0;
         r_len             <= 8'd0;
      end else begin
         if (axi.WR_DATA_VALID && axi.WR_DATA_READY && axi.WR_DATA_LAST) begin
            axi.WR_BACK_VALID <= 1'b1;
            axi.WR_BACK_RESP  <= bresp_cfg;
            axi.WR_BACK_ID    <= bid_cfg;
         end else if (axi.WR_BACK_VALID && axi.WR_BACK_READY) begin
            axi.WR_BACK_VALID <= 1'b0;
         end
         if (axi.RD_ADDR_VALID && axi.RD_ADDR_READY) begin
            r_beat            <= 8'd0;
            r_len             <= axi.RD_ADDR_LEN;
            axi.RD_DATA_VALID <= 1'b1;
         end else if (axi.RD_DATA_VALID && axi.RD_DATA_READY) begin
            if (r_beat == r_len) axi.RD_DATA_VALID <= 1'b0;
            r_beat <= r_beat + 8'd1;
         end
      end
   end

   // Monitor: every handshake or done pulse pops one expectation.
   always @(negedge clk) begin
      if (!rst) begin
         if (axi.WR_ADDR_VALID && axi.WR_ADDR_READY) begin
            if (exp_aw.size() == 0) unexpected("aw");
            else check("aw", {axi.WR_ADDR, axi.WR_ADDR_LEN, axi.WR_ADDR_BURST,
                              axi.WR_ADDR_SIZE, axi.WR_ADDR_ID},
                       exp_aw.pop_front());
         end
         if (axi.RD_ADDR_VALID && axi.RD_ADDR_READY) begin
            if (exp_ar.size() == 0) unexpected("ar");
            else check("ar", {axi.RD_ADDR, axi.RD_ADDR_LEN, axi.RD_ADDR_BURST,
                              axi.RD_ADDR_SIZE, axi.RD_ADDR_ID},
                       exp_ar.pop_front());
         end
         if (axi.WR_DATA_VALID && axi.WR_DATA_READY) begin
            if (exp_w.size() == 0) unexpected("w beat");
            else check("w beat", {axi.WR_STRB, axi.WR_DATA, axi.WR_DATA_LAST},
                       exp_w.pop_front());
         end
         if (rdat_valid && rdat_ready) begin
            if (exp_r.size() == 0) unexpected("r beat");
            else check("r beat", {rdat, rdat_last}, exp_r.pop_front());
         end
         if (done) begin
            n_done++;
            if (exp_done.size() == 0) unexpected("done");
            else check("done resp/err", {done_resp, done_err},
                       exp_done.pop_front());
         end
      end
   end

   task automatic issue(input logic wr, input logic [31:0] a,
                        input logic [7:0] l);
      int k;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_len   = l;
      cmd_valid = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!cmd_ready && k < 100);
      if (!cmd_ready) unexpected("cmd_ready timeout");
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      check("cmd_ready busy", cmd_ready, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic feed_w(input int n, input logic [31:0] base);
      int k;
      for (int i = 0; i < n; i++) begin
         wdat       = base + i;
         wdat_valid = 1'b1;
         k = 0;
         do begin
            @(negedge clk);
            k++;
         end while (!wdat_ready && k < 100);
         if (!wdat_ready) begin
            unexpected("wdat_ready timeout");
            break;
         end
         @(posedge clk);
         #1;
      end
      wdat_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!done && k < 600);
      if (!done) $display("FAIL %s: got no done expected done", name);
      if (!done) n_fail++;
      n_checks++;
      @(posedge clk);
      #1;
   endtask

   task automatic push_w(input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++)
         exp_w.push_back({4'hF, base + i, (i == n - 1) ? 1'b1 : 1'b0});
   endtask

   initial begin
      #500000;
      $display("FAIL global watchdog: got no finish expected finish");
      $fatal(1);
   end

   logic stop_toggle;
   int   lat;
   int   d0;

   initial begin
      for (int i = 0; i < 256; i++) begin
         rdata_tab[i] = 32'h0;
         rresp_tab[i] = 2'b00;
      end
      stop_toggle = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst cmd_ready", cmd_ready, 0);
      check("rst valids", {axi.WR_ADDR_VALID, axi.RD_ADDR_VALID,
                           axi.WR_DATA_VALID, rdat_valid}, 0);
      check("rst readys", {axi.WR_BACK_READY, axi.RD_DATA_READY,
                           wdat_ready}, 0);
      check("rst done", {done, done_resp, done_err}, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("cmd_ready after rst", cmd_ready, 1);
      @(posedge clk);
      #1;

      // 1: write 0x100 len=3
      exp_aw.push_back({32'h100, 8'd3, 2'b01, 3'd2, 4'd0});
      push_w(4, 32'hA000_0000);
      exp_done.push_back({2'b00, 1'b0});
      issue(1'b1, 32'h100, 8'd3);
      feed_w(4, 32'hA000_0000);
      wait_done("write len3");

      // 2: read 0x200 len=0
      rdata_tab[0] = 32'hDEADBEEF;
      rlast_at = 8'd0;
      exp_ar.push_back({32'h200, 8'd0, 2'b01, 3'd2, 4'd0});
      exp_r.push_back({32'hDEADBEEF, 1'b1});
      exp_done.push_back({2'b00, 1'b0});
      issue(1'b0, 32'h200, 8'd0);
      wait_done("read len0");

      // 3: read len=7, SLVERR on beat 5, rdat_ready toggling
      for (int i = 0; i < 8; i++) begin
         rdata_tab[i] = 32'h1000 + i;
         exp_r.push_back({32'h1000 + i, (i == 7) ? 1'b1 : 1'b0});
      end
      rresp_tab[4] = 2'b10;
      rlast_at = 8'd7;
      exp_ar.push_back({32'h300, 8'd7, 2'b01, 3'd2, 4'd0});
      exp_done.push_back({2'b10, 1'b0});
      fork
         while (!stop_toggle) begin
            @(posedge clk);
            #1 rdat_ready = ~rdat_ready;
         end
      join_none
      issue(1'b0, 32'h300, 8'd7);
      wait_done("read len7");
      stop_toggle = 1'b1;
      @(posedge clk);
      #2 rdat_ready = 1'b1;
      rresp_tab[4] = 2'b00;

      // 4a: write len=1 with wrong BID
      bid_cfg = 4'h3;
      exp_aw.push_back({32'h400, 8'd1, 2'b01, 3'd2, 4'd0});
      push_w(2, 32'hB000_0000);
      exp_done.push_back({2'b00, 1'b1});
      issue(1'b1, 32'h400, 8'd1);
      feed_w(2, 32'hB000_0000);
      wait_done("write bad id");
      bid_cfg = 4'h0;

      // 4b: read len=3 with LAST on beat 2
      for (int i = 0; i < 4; i++) begin
         rdata_tab[i] = 32'h5000 + i;
         exp_r.push_back({32'h5000 + i, (i == 3) ? 1'b1 : 1'b0});
      end
      rlast_at = 8'd1;
      exp_ar.push_back({32'h500, 8'd3, 2'b01, 3'd2, 4'd0});
      exp_done.push_back({2'b00, 1'b1});
      issue(1'b0, 32'h500, 8'd3);
      wait_done("read early last");

      // write len=255 with EXOKAY: counter must not wrap early
      bresp_cfg = 2'b01;
      exp_aw.push_back({32'h1000, 8'd255, 2'b01, 3'd2, 4'd0});
      push_w(256, 32'hC000_0000);
      exp_done.push_back({2'b01, 1'b0});
      issue(1'b1, 32'h1000, 8'd255);
      feed_w(256, 32'hC000_0000);
      wait_done("write len255");
      bresp_cfg = 2'b00;

      // 5: reset while beat 2 of a len=15 write is pending
      d0 = n_done;
      exp_aw.push_back({32'h600, 8'd15, 2'b01, 3'd2, 4'd0});
      push_w(1, 32'h6000);
      exp_w[0][0] = 1'b0;
      issue(1'b1, 32'h600, 8'd15);
      feed_w(1, 32'h6000);
      ready_w    = 1'b0;
      wdat       = 32'h6001;
      wdat_valid = 1'b1;
      @(negedge clk);
      check("beat2 pending", axi.WR_DATA_VALID, 1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid rst valids", {axi.WR_ADDR_VALID, axi.RD_ADDR_VALID,
                               axi.WR_DATA_VALID, rdat_valid}, 0);
      check("mid rst readys", {axi.WR_BACK_READY, axi.RD_DATA_READY,
                               wdat_ready, cmd_ready, done}, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      wdat_valid = 1'b0;
      ready_w    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("cmd_ready after mid rst", cmd_ready, 1);
      check("no done on rst", n_done, d0);
      @(posedge clk);
      #1;

      // 6: address phase never accepted
      ready_ar = 1'b0;
      rlast_at = 8'd0;
`ifdef AXI_MASTER_TIMEOUT_EN
      exp_done.push_back({2'b10, 1'b1});
      issue(1'b0, 32'h700, 8'd0);
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (done) begin
            lat = i;
            break;
         end
      end
      check("timeout latency", lat, 17);
      check("timeout ar valid", axi.RD_ADDR_VALID, 0);
`else
      d0 = n_done;
      issue(1'b0, 32'h700, 8'd0);
      repeat (40) @(negedge clk);
      #1;
      check("no done without watchdog", n_done, d0);
      check("ar still pending", axi.RD_ADDR_VALID, 1);
`endif
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      ready_ar = 1'b1;
      repeat (2) @(posedge clk);

      check("aw queue drained", exp_aw.size(), 0);
      check("ar queue drained", exp_ar.size(), 0);
      check("w queue drained", exp_w.size(), 0);
      check("r queue drained", exp_r.size(), 0);
      check("done queue drained", exp_done.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
